// File: rtl/invert_pkg.sv
// Shared definitions for the bit-serial two's-complement unit.
// Holds the FSM state type, the default word length and the counter width helper.
package invert_pkg;

    typedef enum logic {
        PASS   = 1'b0,
        INVERT = 1'b1
    } inv_state_t;

    localparam int WORD_W_DEFAULT = 8;

    // A one-bit word still needs a one-bit counter, even though it never leaves 0.
    function automatic int ctr_width(input int word_w);
        return (word_w <= 1) ? 1 : $clog2(word_w);
    endfunction

endpackage

// File: rtl/invert_bit_ctr.sv
// Modulo-WORD_W bit counter that frames the serial words.
// last_o flags the final bit of the current word.
module invert_bit_ctr
    import invert_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic last_o
);

    localparam int CW = ctr_width(WORD_W);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last_o = (cnt_q == CW'(WORD_W - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (last_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/invert.sv
// Bit-serial two's complement, LSB first: copy bits up to and including the
// first 1, invert every later bit, and re-arm at each word boundary.
module invert
    import invert_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic t_clk,
    input  logic r,
    input  logic i,
    output logic y
);

    inv_state_t state_q;
    inv_state_t state_d;
    logic       y_q;
    logic       y_d;
    logic       last;

    invert_bit_ctr #(
        .WORD_W (WORD_W)
    ) u_bit_ctr (
        .clk_i  (t_clk),
        .rst_ni (r),
        .last_o (last)
    );

    // The current bit always uses the pre-edge state; the word boundary only
    // affects what the next word starts from.
    always_comb begin
        state_d = state_q;
        y_d     = i ^ (state_q == INVERT);
        if (last) begin
            state_d = PASS;
        end else if ((state_q == PASS) && i) begin
            state_d = INVERT;
        end
    end

    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            state_q <= PASS;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_invert.sv
// Directed and randomised checks of the serial two's-complement unit
// at word lengths 4, 8 and 1.
module tb_invert;

    logic t_clk;
    logic r;
    logic i4, i8, i1;
    logic y4, y8, y1;

    int total = 0;
    int bad   = 0;

    invert #(.WORD_W(4)) u_dut4 (.t_clk(t_clk), .r(r), .i(i4), .y(y4));
    invert #(.WORD_W(8)) u_dut8 (.t_clk(t_clk), .r(r), .i(i8), .y(y8));
    invert #(.WORD_W(1)) u_dut1 (.t_clk(t_clk), .r(r), .i(i1), .y(y1));

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one WORD_W=4 operand LSB first and checks each result bit one edge later.
    task automatic send4(input logic [3:0] op, input logic [3:0] exp, input string tag);
        for (int k = 0; k < 4; k++) begin
            i4 = op[k];
            @(posedge t_clk);
            #1;
            chk($sformatf("%s_bit%0d", tag, k), {7'd0, y4}, {7'd0, exp[k]});
        end
        $display("w4 operand=%0d y=%0d expected=%0d", op, exp, exp);
    endtask

    logic [7:0] op8;
    logic [7:0] got8;
    logic [7:0] exp8;
    logic       prev_i1;

    initial begin
        r  = 1'b0;
        i4 = 1'b0;
        i8 = 1'b0;
        i1 = 1'b0;

        // Held in reset while inputs toggle: every output stays low.
        for (int n = 0; n < 4; n++) begin
            i4 = ~i4;
            i8 = ~i8;
            i1 = ~i1;
            @(posedge t_clk);
            #1;
            chk("rst_hold_y4", {7'd0, y4}, 8'd0);
            chk("rst_hold_y8", {7'd0, y8}, 8'd0);
            chk("rst_hold_y1", {7'd0, y1}, 8'd0);
        end
        i4 = 1'b0;
        i8 = 1'b0;
        i1 = 1'b0;
        r  = 1'b1;

        // Back-to-back WORD_W=4 words straight after release.
        send4(4'd6, 4'd10, "op6");
        send4(4'd0, 4'd0,  "op0");
        send4(4'd8, 4'd8,  "op8");
        send4(4'd1, 4'd15, "op1");
        send4(4'd2, 4'd14, "op2");

        // Two bits of operand 1, then an asynchronous reset between edges.
        i4 = 1'b1;
        @(posedge t_clk);
        #1;
        chk("mid_bit0", {7'd0, y4}, 8'd1);
        i4 = 1'b0;
        @(posedge t_clk);
        #1;
        chk("mid_bit1", {7'd0, y4}, 8'd1);
        #2;
        r = 1'b0;
        #1;
        chk("async_fall_y4", {7'd0, y4}, 8'd0);
        $display("async reset mid-word: y4=%b", y4);
        @(posedge t_clk);
        #1;
        r = 1'b1;
        send4(4'd3, 4'd13, "op3_after_rst");

        // Re-frame both remaining instances, then stream 100 WORD_W=8 words.
        r = 1'b0;
        @(posedge t_clk);
        #1;
        r = 1'b1;
        prev_i1 = 1'b0;
        for (int w = 0; w < 100; w++) begin
            case (w)
                0:       op8 = 8'd0;
                1:       op8 = 8'd128;
                2:       op8 = 8'd255;
                3:       op8 = 8'd1;
                default: op8 = 8'($urandom_range(0, 255));
            endcase
            exp8 = 8'((9'd256 - {1'b0, op8}) % 9'd256);
            got8 = 8'd0;
            for (int k = 0; k < 8; k++) begin
                i8      = op8[k];
                prev_i1 = i1;
                i1      = 1'($urandom_range(0, 1));
                @(posedge t_clk);
                #1;
                got8[k] = y8;
                chk($sformatf("w1_w%0d_b%0d", w, k), {7'd0, y1}, {7'd0, i1});
            end
            chk($sformatf("w8_word%0d", w), got8, exp8);
            $display("w8 operand=%0d y=%0d expected=%0d", op8, got8, exp8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/invert.md
# invert

Serial two's-complement unit: accepts an operand one bit per clock, LSB first, on `i`, and emits its two's complement one bit per clock on `y`. It uses the copy-until-first-one, then invert rule. It sits on a bit-serial datapath between a serializer and any bit-serial consumer, and needs no word-wide storage. Words are framed by a fixed bit count, so consecutive operands stream back-to-back without gaps.

## Interface
- `WORD_W`, default 8: operand length in bits; must be ≥ 1. The complement state re-arms after every `WORD_W` bits.
- `t_clk`  input  1  clock; all state updates on the rising edge.
- `r`  input  1  reset, asynchronous, active-low. `r`=0 forces reset immediately; release is sampled on `t_clk`.
- `i`  input  1  serial operand bit, LSB first, one bit per `t_clk` cycle.
- `y`  output  1  serial result bit, LSB first, registered.

## Operation
- Two-state FSM per word:
  - PASS: no 1 seen yet in the current word.
  - INVERT: a 1 has been seen.
- On each rising edge with `r`=1:
  - `y` ← `i` XOR (state==INVERT).
  - In PASS, if `i`=1, the next state is INVERT. The bit that caused the transition is passed through unchanged.
  - INVERT stays INVERT until the word ends.
- Bit counter `cnt` runs 0..`WORD_W`-1 and increments every cycle.
  - At `cnt`==`WORD_W`-1 the counter wraps to 0.
  - On that same edge, the FSM returns to PASS regardless of `i`. The current bit is still processed with the pre-edge state.
- Arithmetic is modulo 2^`WORD_W`:
  - 0 maps to 0.
  - The most-negative value 2^(`WORD_W`-1) maps to itself.
- Reset (`r`=0), asynchronous:
  - `y`=0
  - state=PASS
  - `cnt`=0
- The first bit sampled after reset release is bit 0 of a new word.

## Timing
- Latency: result bit k appears on `y` after the edge that samples operand bit k, i.e. one cycle behind `i`, and holds for one full cycle.
- Throughput: one bit per cycle, continuous. Word n+1 bit 0 may follow word n bit `WORD_W`-1 directly.
- Reset asserted mid-word:
  - The partial word is discarded.
  - `y` drops to 0 without waiting for a clock.
  - Framing restarts at bit 0 after release.
- `i` must be stable around the rising edge. There is no input valid qualifier; every cycle outside reset is a data bit.
- `WORD_W`=1: the FSM re-arms every cycle and `y` equals the previous `i`.

## Structure
- Shared package `invert_pkg`:
  - state enum `inv_state_t` {PASS, INVERT}
  - default `WORD_W` constant
- Sub-module `invert_bit_ctr`:
  - parameterised modulo-`WORD_W` counter
  - width $clog2(`WORD_W`), minimum 1
  - asynchronous active-low clear
  - outputs `last` when `cnt`==`WORD_W`-1
- The top level holds the FSM and the `y` register.

## Test plan
- Reset: hold `r`=0, toggle `i` for several edges -> `y`=0 throughout. Assert `r`=0 asynchronously between edges -> `y` falls immediately.
- `WORD_W`=4, operand 6 (bits 0,1,1,0 LSB first) -> `y` sequence 0,1,0,1 (value 10 = −6), each bit one cycle late.
- `WORD_W`=4, operand 0 (0,0,0,0) -> `y` 0,0,0,0. Operand 8 (0,0,0,1) -> `y` 0,0,0,1 (most-negative maps to itself).
- Back-to-back words, `WORD_W`=4: operand 1 (1,0,0,0), then operand 2 (0,1,0,0) -> `y` 1,1,1,1 then 0,1,1,1. This proves the FSM re-arms to PASS at the word boundary.
- Reset mid-word: after 2 bits of operand 1, pulse `r`=0. Then send operand 3 (1,1,0,0) -> `y` 1,0,1,1 (13 = −3), framed from the first bit after release.
- `WORD_W`=8 random operands, 100 words -> reassembled `y` word == (2^8 − operand) mod 2^8 for every word.
